// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification helpers for seq_alu.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Bit-serial datapath for MUL (shift-add) and DIVU/REMU (restoring division).
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  // acc: product accumulator or partial remainder
  // opa: shifting multiplicand, or dividend shifting out while quotient shifts in
  // opb: shifting multiplier, or fixed divisor
  logic             busy_q;
  logic             div_q;
  logic             rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] shifted_rem;

  always_comb begin
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    shifted_rem = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
    trial       = {acc_q, opa_q[WIDTH-1]} - {1'b0, opb_q};
    if (div_q) begin
      acc_d = trial[WIDTH] ? shifted_rem : trial[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end
  end

  // The final step's value is forwarded so the top can capture it on the same edge.
  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = (div_q && !rem_q) ? opa_d : acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= is_div(op_i);
      rem_q  <= (op_i == ALU_REMU);
      cnt_q  <= CW'(WIDTH - 1);
      acc_q  <= '0;
      opa_q  <= a_i;
      opb_q  <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle ops plus iterative MUL/DIVU/REMU.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_e                  state_q;
  logic [WIDTH-1:0]        result_q;
  logic                    zero_q;
  logic                    illegal_q;
  logic                    out_valid_q;
  logic                    in_ready_q;

  logic [WIDTH-1:0]        sc_result_d;
  logic                    sc_illegal_d;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0]          shamt;
  logic                    accept;
  logic                    start_iter;
  logic                    iter_done;
  logic [WIDTH-1:0]        iter_result;

  assign a_s   = a;
  assign shamt = b[SHW-1:0];

  // DIVU/REMU only reach this path with b == 0, so they yield the divide-by-zero values.
  always_comb begin
    sc_result_d  = '0;
    sc_illegal_d = 1'b0;
    case (alu_ctrl)
      ALU_AND:  sc_result_d = a & b;
      ALU_OR:   sc_result_d = a | b;
      ALU_ADD:  sc_result_d = a + b;
      ALU_SLL:  sc_result_d = a << shamt;
      ALU_SUB:  sc_result_d = a - b;
      ALU_SRL:  sc_result_d = a >> shamt;
      ALU_SRA:  sc_result_d = a_s >>> shamt;
      ALU_MUL:  sc_result_d = '0;
      ALU_DIVU: sc_result_d = '1;
      ALU_REMU: sc_result_d = a;
      default:  sc_illegal_d = 1'b1;
    endcase
  end

  assign accept     = in_valid && in_ready_q;
  assign start_iter = accept && is_multicycle(alu_ctrl) && !(is_div(alu_ctrl) && (b == '0));

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_iter),
    .op_i     (alu_ctrl),
    .a_i      (a),
    .b_i      (b),
    .done_o   (iter_done),
    .result_o (iter_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (start_iter) begin
              state_q <= BUSY;
            end else begin
              state_q     <= DONE;
              result_q    <= sc_result_d;
              zero_q      <= (sc_result_d == '0);
              illegal_q   <= sc_illegal_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_q     <= DONE;
            result_q    <= iter_result;
            zero_q      <= (iter_result == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv32 = 1'b0, ordy32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  c32 = '0;
  logic        ir32, ov32, z32, il32;
  logic [31:0] r32;

  logic        iv8 = 1'b0, ordy8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  c8 = '0;
  logic        ir8, ov8, z8, il8;
  logic [7:0]  r8;

  logic        sel = 1'b0;
  logic        o_ov, o_ir, o_z, o_il;
  logic [31:0] o_res;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .alu_ctrl(c32), .out_valid(ov32), .out_ready(ordy32), .result(r32), .zero(z32),
    .illegal(il32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .alu_ctrl(c8), .out_valid(ov8), .out_ready(ordy8), .result(r8), .zero(z8),
    .illegal(il8)
  );

  always_comb begin
    o_ov  = sel ? ov8 : ov32;
    o_ir  = sel ? ir8 : ir32;
    o_z   = sel ? z8  : z32;
    o_il  = sel ? il8 : il32;
    o_res = sel ? {24'h0, r8} : r32;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input bit s, input logic v, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    if (s) begin
      iv8 = v; c8 = op; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      iv32 = v; c32 = op; a32 = x; b32 = y;
    end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) ordy8 = v;
    else   ordy32 = v;
  endtask

  task automatic run_op(input bit s, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic eil,
                        input int elat, input int hold, input bit early);
    exp_t        e;
    exp_t        got;
    int          cyc;
    logic [31:0] held;
    e.res = er; e.z = (er == 32'h0); e.ill = eil; e.lat = elat;
    sb.push_back(e);
    sel = s;
    @(negedge clk);
    set_ordy(s, early);
    drive(s, 1'b1, op, x, y);
    chk("in_ready_idle", o_ir, 1);
    @(negedge clk);
    drive(s, 1'b0, op, $urandom, $urandom);
    cyc = 1;
    while (!o_ov && cyc < 100) begin
      chk("in_ready_busy", o_ir, 0);
      @(negedge clk);
      cyc++;
    end
    got = sb.pop_front();
    chk("out_valid", o_ov, 1);
    chk("latency", cyc, got.lat);
    chk("result", o_res, got.res);
    chk("zero", o_z, got.z);
    chk("illegal", o_il, got.ill);
    chk("in_ready_done", o_ir, 0);
    if (early) begin
      @(negedge clk);
      chk("single_cycle_present", o_ov, 0);
      chk("in_ready_after", o_ir, 1);
      set_ordy(s, 1'b0);
    end else begin
      held = o_res;
      for (int i = 0; i < hold; i++) begin
        drive(s, (i % 2 == 1), ALU_ADD, 32'h1, 32'h1);
        @(negedge clk);
        chk("hold_valid", o_ov, 1);
        chk("hold_result", o_res, held);
        chk("hold_illegal", o_il, got.ill);
        chk("hold_in_ready", o_ir, 0);
      end
      drive(s, 1'b1, ALU_ADD, 32'h1, 32'h1);
      set_ordy(s, 1'b1);
      @(negedge clk);
      drive(s, 1'b0, ALU_ADD, 32'h0, 32'h0);
      set_ordy(s, 1'b0);
      chk("taken_valid", o_ov, 0);
      chk("taken_in_ready", o_ir, 1);
      @(negedge clk);
      chk("no_stray_accept", o_ov, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov32, 0);
    chk("rst_in_ready", ir32, 1);
    chk("rst_result", r32, 0);
    chk("rst_zero", z32, 1);
    chk("rst_illegal", il32, 0);
    rst_n = 1'b1;

    run_op(0, ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 0);
    run_op(0, ALU_SUB,  32'h5,        32'h5,        32'h0,        0, 1, 2, 0);
    run_op(0, ALU_SRA,  32'h80000000, 32'h21,       32'hC0000000, 0, 1, 0, 0);
    run_op(0, ALU_SRL,  32'h80000000, 32'h21,       32'h40000000, 0, 1, 0, 0);
    run_op(0, ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 1);
    run_op(0, ALU_OR,   32'hF0F0F0F0, 32'h0F00000F, 32'hFFF0F0FF, 0, 1, 0, 0);
    run_op(0, ALU_SLL,  32'h1,        32'hFFFFFFE4, 32'h10,       0, 1, 0, 0);
    run_op(0, ALU_MUL,  32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD, 0, 33, 1, 0);
    run_op(0, ALU_DIVU, 32'd100,      32'd7,        32'd14,       0, 33, 0, 0);
    run_op(0, ALU_REMU, 32'd100,      32'd7,        32'd2,        0, 33, 0, 1);
    run_op(0, ALU_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 0, 1, 0, 0);
    run_op(0, ALU_REMU, 32'd100,      32'd0,        32'd100,      0, 1, 0, 0);
    run_op(0, 4'b1111,  32'h12345678, 32'h9,        32'h0,        1, 1, 5, 0);

    for (int k = 0; k < 3; k++) begin
      x = $urandom;
      y = $urandom_range(1, 65535);
      run_op(0, ALU_MUL,  x, y, x * y, 0, 33, 0, 0);
      run_op(0, ALU_DIVU, x, y, x / y, 0, 33, 0, 0);
      run_op(0, ALU_REMU, x, y, x % y, 0, 33, 0, 0);
    end

    // Abandon a MUL partway through with an asynchronous reset.
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, ALU_MUL, 32'd5, 32'd7);
    @(negedge clk);
    drive(0, 1'b0, ALU_ADD, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov32, 0);
    chk("midrst_in_ready", ir32, 1);
    chk("midrst_result", r32, 0);
    chk("midrst_zero", z32, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_output", ov32, 0);
    run_op(0, ALU_ADD, 32'd2, 32'd2, 32'd4, 0, 1, 0, 0);

    run_op(1, ALU_ADD,  32'h7F, 32'h01, 32'h80, 0, 1, 0, 0);
    run_op(1, ALU_MUL,  32'h0F, 32'h11, 32'hFF, 0, 9, 1, 0);
    run_op(1, ALU_DIVU, 32'd100, 32'd7, 32'd14, 0, 9, 0, 0);
    run_op(1, ALU_REMU, 32'hFF, 32'h10, 32'h0F, 0, 9, 0, 0);
    run_op(1, ALU_SRA,  32'h80, 32'h09, 32'hC0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
